// File: rtl/mario_pkg.sv
// Shared game constants: playfield geometry, MOGU scheduler state encoding,
// LFSR seed/taps and a small bit-select helper.
package mario_pkg;

  localparam int unsigned BW       = 240;
  localparam int unsigned MGMW     = 16;
  localparam int unsigned GROUND_R = 144;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SPAWN = 2'd2,
    S_MOVE  = 2'd3
  } mogu_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // One-hot of the lowest set bit (0 when v is 0)
  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/mogu_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; only rst reloads the seed.
module mogu_lfsr (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);
  import mario_pkg::*;

  logic [7:0] q_q, q_d;

  // Shift left, feeding back the XOR of the tapped bits
  always_comb begin
    q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  // State register, seeded on reset
  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mogu_scheduler.sv
// MOGU wave scheduler: picks a random slot mask per wave, releases slots
// GAP ticks apart, marches them left on each tick and tracks escapes/kills.
module mogu_scheduler #(
  parameter int unsigned BW       = mario_pkg::BW,
  parameter int unsigned MGMW     = mario_pkg::MGMW,
  parameter int unsigned SPAWN_C  = BW - MGMW,
  parameter int unsigned GROUND_R = mario_pkg::GROUND_R,
  parameter int unsigned STEP     = 2,
  parameter int unsigned GAP      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        clear,
  input  logic        wave_req,
  input  logic [3:0]  alive,
  output logic [3:0]  MOGU,
  output logic [10:0] C1,
  output logic [10:0] C2,
  output logic [10:0] C3,
  output logic [10:0] C4,
  output logic [10:0] R1,
  output logic [10:0] R2,
  output logic [10:0] R3,
  output logic [10:0] R4,
  output logic [3:0]  escaped,
  output logic [7:0]  wave,
  output logic        busy
);
  import mario_pkg::*;

  mogu_state_e state_q, state_d;
  logic [3:0]  mogu_q, mogu_d;
  logic [3:0]  rel_q, rel_d;
  logic [3:0]  esc_q, esc_d;
  logic [7:0]  wave_q, wave_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [10:0] c_q [4];
  logic [10:0] c_d [4];

  logic [7:0]  lfsr_q;
  logic        unused_lfsr_hi;
  logic [3:0]  pending;
  logic        rel_now;
  logic [3:0]  rel_mask;
  logic        wave_done;

  mogu_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[7:4];

  // Release and wave-completion decode shared by next-state and datapath.
  // gcnt==0 only on SPAWN entry; afterwards the GAP-th tick triggers release.
  always_comb begin
    pending   = mogu_q & ~rel_q;
    rel_now   = (state_q == S_SPAWN) && (pending != '0) &&
                ((gcnt_q == '0) || (tick && (gcnt_q == 8'd1)));
    rel_mask  = rel_now ? lowest_set(pending) : '0;
    wave_done = (mogu_q & alive & ~esc_q) == '0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; clear forces IDLE from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wave_req) state_d = S_LOAD;
      S_LOAD:  state_d = S_SPAWN;
      S_SPAWN: if ((pending & ~rel_mask) == '0) state_d = S_MOVE;
      S_MOVE:  if (wave_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // Datapath next-state: wave load on IDLE->LOAD, releases, movement, wave end
  always_comb begin
    mogu_d = mogu_q;
    rel_d  = rel_q;
    esc_d  = esc_q;
    wave_d = wave_q;
    gcnt_d = gcnt_q;
    for (int unsigned n = 0; n < 4; n++) c_d[n] = c_q[n];

    if (clear) begin
      mogu_d = '0;
      rel_d  = '0;
      esc_d  = '0;
      wave_d = '0;
      gcnt_d = '0;
    end else begin
      // Wave setup is registered on the edge into LOAD so MOGU is valid in LOAD
      if ((state_q == S_IDLE) && wave_req) begin
        mogu_d = (lfsr_q[3:0] == '0) ? 4'b0001 : lfsr_q[3:0];
        rel_d  = '0;
        esc_d  = '0;
        gcnt_d = '0;
        for (int unsigned n = 0; n < 4; n++) c_d[n] = 11'(SPAWN_C);
      end

      if (state_q == S_SPAWN) begin
        rel_d = rel_q | rel_mask;
        if (rel_now)                      gcnt_d = 8'(GAP);
        else if (tick && (gcnt_q != '0))  gcnt_d = gcnt_q - 8'd1;
      end

      // Compare before subtracting so a column never wraps below zero
      if (((state_q == S_SPAWN) || (state_q == S_MOVE)) && tick) begin
        for (int unsigned n = 0; n < 4; n++) begin
          if (rel_q[n] && alive[n] && !esc_q[n]) begin
            if (c_q[n] <= 11'(STEP)) esc_d[n] = 1'b1;
            else                     c_d[n]   = c_q[n] - 11'(STEP);
          end
        end
      end

      if ((state_q == S_MOVE) && wave_done) begin
        mogu_d = '0;
        if (wave_q != '1) wave_d = wave_q + 8'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mogu_q <= '0;
      rel_q  <= '0;
      esc_q  <= '0;
      wave_q <= '0;
      gcnt_q <= '0;
      for (int unsigned n = 0; n < 4; n++) c_q[n] <= 11'(SPAWN_C);
    end else begin
      mogu_q <= mogu_d;
      rel_q  <= rel_d;
      esc_q  <= esc_d;
      wave_q <= wave_d;
      gcnt_q <= gcnt_d;
      for (int unsigned n = 0; n < 4; n++) c_q[n] <= c_d[n];
    end
  end

  assign MOGU    = mogu_q;
  assign escaped = esc_q;
  assign wave    = wave_q;
  assign busy    = (state_q != S_IDLE);
  assign C1      = c_q[0];
  assign C2      = c_q[1];
  assign C3      = c_q[2];
  assign C4      = c_q[3];
  assign R1      = 11'(GROUND_R);
  assign R2      = 11'(GROUND_R);
  assign R3      = 11'(GROUND_R);
  assign R4      = 11'(GROUND_R);

endmodule

// File: tb/tb_mogu_scheduler.sv
// Bench for mogu_scheduler: hand-derived vector table for the first wave,
// then a cycle model feeding a scoreboard queue for the longer sequences.
module tb_mogu_scheduler;

  logic        clk = 1'b0;
  logic        rst, tick, clear, wave_req;
  logic [3:0]  alive;
  logic [3:0]  MOGU, escaped;
  logic [10:0] C1, C2, C3, C4, R1, R2, R3, R4;
  logic [7:0]  wave;
  logic        busy;
  logic [10:0] dut_c [4];

  mogu_scheduler #(
    .BW(240), .MGMW(16), .SPAWN_C(224), .GROUND_R(144), .STEP(2), .GAP(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .clear(clear), .wave_req(wave_req),
    .alive(alive), .MOGU(MOGU), .C1(C1), .C2(C2), .C3(C3), .C4(C4),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .escaped(escaped), .wave(wave),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_c[0] = C1; dut_c[1] = C2; dut_c[2] = C3; dut_c[3] = C4;
  end

  localparam logic [10:0] SPAWNV = 11'd224;
  localparam logic [10:0] STEPV  = 11'd2;
  localparam int          GAPV   = 8;

  typedef enum int {M_IDLE, M_LOAD, M_SPAWN, M_MOVE} mst_e;

  typedef struct packed {
    logic [3:0]       mogu;
    logic [3:0][10:0] c;
    logic [3:0]       esc;
    logic [7:0]       wave;
    logic             busy;
  } exp_t;

  typedef struct packed {
    logic r, t, cl, wr;
    logic [3:0]  al;
    logic [3:0]  mogu;
    logic [10:0] c1, c3;
    logic [3:0]  esc;
    logic [7:0]  wave;
    logic        busy;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model state
  mst_e        m_st;
  logic [3:0]  m_mogu, m_rel, m_esc;
  logic [10:0] m_c [4];
  logic [7:0]  m_wave, m_lfsr;
  bit          m_first;
  int          m_since;

  task automatic model_step(input logic r, t, cl, wr, input logic [3:0] al);
    logic [7:0] l_now;
    logic [3:0] pend, esc_before;
    exp_t e;
    l_now = m_lfsr;
    if (r) begin
      m_st = M_IDLE; m_mogu = 0; m_rel = 0; m_esc = 0; m_wave = 0;
      m_first = 0; m_since = 0; m_lfsr = 8'hA5;
      for (int n = 0; n < 4; n++) m_c[n] = SPAWNV;
    end else begin
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      if (cl) begin
        m_st = M_IDLE; m_mogu = 0; m_esc = 0; m_wave = 0; m_rel = 0;
      end else begin
        case (m_st)
          M_IDLE: if (wr) begin
            m_mogu = (l_now[3:0] == 4'd0) ? 4'd1 : l_now[3:0];
            m_esc = 0; m_rel = 0;
            for (int n = 0; n < 4; n++) m_c[n] = SPAWNV;
            m_st = M_LOAD;
          end
          M_LOAD: begin
            m_st = M_SPAWN; m_first = 1; m_since = 0;
          end
          default: begin
            esc_before = m_esc;
            if (t) begin
              for (int n = 0; n < 4; n++) begin
                if (m_rel[n] && al[n] && !m_esc[n]) begin
                  if (m_c[n] <= STEPV) m_esc[n] = 1'b1;
                  else                 m_c[n] = m_c[n] - STEPV;
                end
              end
            end
            if (m_st == M_SPAWN) begin
              if (m_first || (t && m_since == GAPV - 1)) begin
                pend = m_mogu & ~m_rel;
                for (int n = 0; n < 4; n++) begin
                  if (pend[n]) begin m_rel[n] = 1'b1; break; end
                end
                m_first = 0; m_since = 0;
                if ((m_mogu & ~m_rel) == 4'd0) m_st = M_MOVE;
              end else if (t) begin
                m_since++;
              end
            end else if ((m_mogu & al & ~esc_before) == 4'd0) begin
              m_st = M_IDLE;
              if (m_wave != 8'd255) m_wave++;
              m_mogu = 0;
            end
          end
        endcase
      end
    end
    e.mogu = m_mogu;
    for (int n = 0; n < 4; n++) e.c[n] = m_c[n];
    e.esc  = m_esc;
    e.wave = m_wave;
    e.busy = (m_st != M_IDLE);
    sb.push_back(e);
  endtask

  task automatic check_q();
    exp_t e, a;
    a = {MOGU, C4, C3, C2, C1, escaped, wave, busy};
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: no expected entry at t=%0t", $time);
    end else begin
      e = sb.pop_front();
      if (a != e || {R1, R2, R3, R4} != {4{11'd144}}) begin
        n_bad++;
        $display("FAIL sb t=%0t: got mogu=%h c=%0d/%0d/%0d/%0d esc=%h wave=%0d busy=%b r1=%0d, want mogu=%h c=%0d/%0d/%0d/%0d esc=%h wave=%0d busy=%b r=144",
                 $time, a.mogu, a.c[0], a.c[1], a.c[2], a.c[3], a.esc, a.wave, a.busy, R1,
                 e.mogu, e.c[0], e.c[1], e.c[2], e.c[3], e.esc, e.wave, e.busy);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++; n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic cycle(input logic r, t, cl, wr, input logic [3:0] al);
    rst = r; tick = t; clear = cl; wave_req = wr; alive = al;
    model_step(r, t, cl, wr, al);
    @(posedge clk); #1;
    check_q();
  endtask

  function automatic vec_t mk(input logic r, t, cl, wr, input logic [3:0] al,
                              input logic [3:0] mg, input logic [10:0] c1, c3,
                              input logic [3:0] es, input logic [7:0] wv, input logic bz);
    vec_t v;
    v.r = r; v.t = t; v.cl = cl; v.wr = wr; v.al = al;
    v.mogu = mg; v.c1 = c1; v.c3 = c3; v.esc = es; v.wave = wv; v.busy = bz;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    int   kn, k;
    bit   hit;
    logic [3:0] al, saved;

    // first wave: mask 0101 from seed A5, slot0 released on SPAWN entry,
    // slot2 on the 8th tick after it
    tbl[0]  = mk(1, 0, 0, 0, 4'hF, 4'h0, 224, 224, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 4'hF, 4'h5, 224, 224, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 4'hF, 4'h5, 224, 224, 0, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 224, 224, 0, 0, 1);
    tbl[4]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 222, 224, 0, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 220, 224, 0, 0, 1);
    tbl[6]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 218, 224, 0, 0, 1);
    tbl[7]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 216, 224, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 214, 224, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 0, 4'hF, 4'h5, 212, 224, 0, 0, 1);
    tbl[10] = mk(0, 1, 0, 0, 4'hF, 4'h5, 210, 224, 0, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 4'hF, 4'h5, 208, 224, 0, 0, 1);
    tbl[12] = mk(0, 1, 0, 0, 4'hF, 4'h5, 206, 222, 0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].r, tbl[i].t, tbl[i].cl, tbl[i].wr, tbl[i].al);
      chk($sformatf("tbl_row%0d", i),
          64'({MOGU, C1, C3, escaped, wave, busy}),
          64'({tbl[i].mogu, tbl[i].c1, tbl[i].c3, tbl[i].esc, tbl[i].wave, tbl[i].busy}));
    end

    // escape: both slots run off the left edge, wave ends
    for (k = 0; k < 400 && m_st != M_IDLE; k++) cycle(0, 1, 0, 0, 4'hF);
    if (m_st != M_IDLE) timeout("escape_wave_end");
    chk("esc_mask", 64'(escaped), 64'h5);
    chk("esc_c1_hold", 64'(C1), 64'd2);
    chk("esc_wave1", 64'(wave), 64'd1);
    chk("esc_busy", 64'(busy), 64'd0);

    // kill on the escaping tick wins over escape
    cycle(0, 0, 0, 1, 4'hF);
    cycle(0, 0, 0, 0, 4'hF);
    kn = 0;
    for (int n = 3; n >= 0; n--) if (m_mogu[n]) kn = n;
    al = 4'hF; hit = 0;
    for (k = 0; k < 600 && m_st != M_IDLE; k++) begin
      if (!hit && m_rel[kn] && m_c[kn] <= STEPV) begin al[kn] = 1'b0; hit = 1; end
      cycle(0, 1, 0, 0, al);
    end
    if (!hit) timeout("kill_reach_edge");
    if (m_st != M_IDLE) timeout("kill_wave_end");
    chk("kill_no_esc", 64'(escaped[kn]), 64'd0);
    chk("kill_c_frozen", 64'(dut_c[kn]), 64'd2);
    chk("kill_wave2", 64'(wave), 64'd2);

    // clear in MOVE
    cycle(0, 0, 0, 1, 4'hF);
    cycle(0, 0, 0, 0, 4'hF);
    for (k = 0; k < 200 && m_st != M_MOVE; k++) cycle(0, 1, 0, 0, 4'hF);
    if (m_st != M_MOVE) timeout("clear_reach_move");
    repeat (3) cycle(0, 1, 0, 0, 4'hF);
    cycle(0, 1, 1, 0, 4'hF);
    chk("clear_mogu", 64'(MOGU), 64'd0);
    chk("clear_wave", 64'(wave), 64'd0);
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_esc", 64'(escaped), 64'd0);

    // wave_req held through LOAD and SPAWN is ignored
    cycle(0, 0, 0, 1, 4'hF);
    saved = m_mogu;
    cycle(0, 0, 0, 1, 4'hF);
    for (k = 0; k < 100 && m_st == M_SPAWN; k++) cycle(0, 1, 0, 1, 4'hF);
    if (m_st != M_MOVE) timeout("spawn_reach_move");
    chk("spawn_req_mogu", 64'(MOGU), 64'(saved));
    cycle(0, 1, 0, 0, 4'h0);
    chk("spawn_wave1", 64'(wave), 64'd1);

    // saturation: kill everything, back-to-back waves
    for (k = 0; k < 20000 && m_wave != 8'd255; k++) cycle(0, 1, 0, 1, 4'h0);
    if (m_wave != 8'd255) timeout("sat_reach");
    chk("sat_255", 64'(wave), 64'd255);
    repeat (80) cycle(0, 1, 0, 1, 4'h0);
    chk("sat_hold", 64'(wave), 64'd255);

    // reset mid-wave, with clear also high, then reseeded mask
    for (k = 0; k < 50 && m_st != M_SPAWN; k++) cycle(0, 1, 0, 1, 4'h0);
    cycle(1, 1, 1, 1, 4'hF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wave", 64'(wave), 64'd0);
    chk("rst_mogu", 64'(MOGU), 64'd0);
    chk("rst_c1", 64'(C1), 64'd224);
    cycle(0, 0, 0, 1, 4'hF);
    chk("rst_reseed_mask", 64'(MOGU), 64'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
